lap_tracker: RTL

//   Consumes the car position (pos_x/pos_y) produced by the physics engine and the

---
 rtl/lap_tracker.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lap_tracker.sv
// -----------------------------------------------------------------------------
// lap_tracker
//
// Purpose:
//   Watches the car position coming from the physics engine together with the
//   game state from the state encoder. It detects entries into the checkpoint
//   and finish-line rectangles, counts completed laps, times the current lap
//   in centiseconds and raises race_done once the required number of laps has
//   been driven. race_done feeds the state encoder's RACING->FINISH transition.
//
//   A lap only counts when the car has gone checkpoint -> finish line. The car
//   spawns inside the finish box, so the first finish "entry" after the start
//   is ignored because the checkpoint has not been visited yet.
//
// Optional feature:
//   BEST_LAP_EN  When defined, best_lap_cs tracks the fastest completed lap and
//                survives across races (only rst clears it). When undefined,
//                there is no best-lap register and best_lap_cs reads 16'hFFFF.
//
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   state        in   3   game state (IDLE=0 SETTING=1 COUNTDOWN=3 RACING=4
//                         PAUSE=5 FINISH=6)
//   pos_x        in   10  car x position, 0..319
//   pos_y        in   10  car y position, 0..239
//   lap          out  3   completed laps, 0..NUM_LAPS
//   lap_time_cs  out  16  current-lap time in centiseconds, saturating
//   last_lap_cs  out  16  time of the most recently completed lap
//   best_lap_cs  out  16  fastest completed lap (16'hFFFF when none / disabled)
//   lap_pulse    out  1   one-cycle strobe on each lap completion
//   race_done    out  1   high once lap reaches NUM_LAPS
// -----------------------------------------------------------------------------
module lap_tracker #(
    parameter int NUM_LAPS     = 3,
    parameter int TICKS_PER_CS = 1000000,
    parameter int FIN_X0       = 150,
    parameter int FIN_X1       = 170,
    parameter int FIN_Y0       = 180,
    parameter int FIN_Y1       = 230,
    parameter int CKP_X0       = 150,
    parameter int CKP_X1       = 170,
    parameter int CKP_Y0       = 10,
    parameter int CKP_Y1       = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [2:0]  lap,
    output logic [15:0] lap_time_cs,
    output logic [15:0] last_lap_cs,
    output logic [15:0] best_lap_cs,
    output logic        lap_pulse,
    output logic        race_done
);

    // Game-state encodings shared with the state encoder.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;

    // Prescaler sizing; a one-tick prescaler still needs a 1-bit register.
    localparam int              PS_W    = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_CS - 1);

    // Lap count at which the next finish entry ends the race.
    localparam logic [2:0] LAP_FINAL = 3'(NUM_LAPS - 1);

    // Region bounds narrowed to the coordinate width.
    localparam logic [9:0] FX0 = 10'(FIN_X0);
    localparam logic [9:0] FX1 = 10'(FIN_X1);
    localparam logic [9:0] FY0 = 10'(FIN_Y0);
    localparam logic [9:0] FY1 = 10'(FIN_Y1);
    localparam logic [9:0] CX0 = 10'(CKP_X0);
    localparam logic [9:0] CX1 = 10'(CKP_X1);
    localparam logic [9:0] CY0 = 10'(CKP_Y0);
    localparam logic [9:0] CY1 = 10'(CKP_Y1);

    typedef enum logic [1:0] {
        S_ARMED     = 2'd0,
        S_NEED_CKPT = 2'd1,
        S_NEED_FIN  = 2'd2,
        S_DONE      = 2'd3
    } fsm_t;

    // Centisecond counter increment that sticks at the maximum.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    // Unsigned minimum used by the best-lap tracker.
    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (b < a) ? b : a;
    endfunction

    fsm_t            r_fsm;
    fsm_t            w_fsm_nxt;

    logic            r_in_fin_q;
    logic            r_in_ckp_q;
    logic [2:0]      r_lap;
    logic [15:0]     r_lap_time;
    logic [15:0]     r_last_lap;
    logic [PS_W-1:0] r_presc;
    logic            r_lap_pulse;

    logic            w_in_fin;
    logic            w_in_ckp;
    logic            w_fin_entry;
    logic            w_ckp_entry;
    logic            w_racing;
    logic            w_rearm;
    logic            w_arm;
    logic            w_lap_done;
    logic            w_count_en;
    logic            w_wrap;
    logic            w_race_done;

    // Region detection and rising-edge entries. The *_q copies update every
    // cycle regardless of game state, so a car that drove into a box while
    // paused does not produce a stale entry when racing resumes.
    assign w_in_fin = (pos_x >= FX0) && (pos_x <= FX1) && (pos_y >= FY0) && (pos_y <= FY1);
    assign w_in_ckp = (pos_x >= CX0) && (pos_x <= CX1) && (pos_y >= CY0) && (pos_y <= CY1);

    assign w_fin_entry = w_in_fin & ~r_in_fin_q;
    assign w_ckp_entry = w_in_ckp & ~r_in_ckp_q;

    assign w_racing = (state == ST_RACING);
    assign w_rearm  = (state == ST_IDLE) || (state == ST_SETTING) || (state == ST_COUNTDOWN);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_ARMED;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM: next-state logic. Each FSM state only looks at the one entry it is
    // waiting for, so overlapping regions can never advance it twice.
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (w_rearm) begin
            w_fsm_nxt = S_ARMED;
        end else if (w_racing) begin
            case (r_fsm)
                S_ARMED: begin
                    w_fsm_nxt = S_NEED_CKPT;
                end
                S_NEED_CKPT: begin
                    if (w_ckp_entry) begin
                        w_fsm_nxt = S_NEED_FIN;
                    end
                end
                S_NEED_FIN: begin
                    if (w_fin_entry) begin
                        w_fsm_nxt = (r_lap == LAP_FINAL) ? S_DONE : S_NEED_CKPT;
                    end
                end
                S_DONE: begin
                    w_fsm_nxt = S_DONE;
                end
                default: begin
                    w_fsm_nxt = S_ARMED;
                end
            endcase
        end
    end

    // FSM: outputs and datapath controls
    always_comb begin
        w_arm       = 1'b0;
        w_lap_done  = 1'b0;
        w_count_en  = 1'b0;
        w_race_done = 1'b0;
        case (r_fsm)
            S_ARMED: begin
                w_arm = w_racing;
            end
            S_NEED_CKPT: begin
                w_count_en = w_racing;
            end
            S_NEED_FIN: begin
                w_count_en = w_racing;
                w_lap_done = w_racing & w_fin_entry;
            end
            S_DONE: begin
                w_race_done = 1'b1;
            end
            default: begin
                w_arm = 1'b0;
            end
        endcase
    end

    assign w_wrap = w_count_en && (r_presc == PS_LAST);

    // Lap counter, lap timer and region history. Priority order matters:
    // re-arm/start clears everything, a completion beats a coincident timer
    // tick (the tick is simply dropped), and counting comes last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_fin_q  <= 1'b0;
            r_in_ckp_q  <= 1'b0;
            r_lap       <= 3'd0;
            r_lap_time  <= 16'd0;
            r_last_lap  <= 16'd0;
            r_presc     <= '0;
            r_lap_pulse <= 1'b0;
        end else begin
            r_in_fin_q  <= w_in_fin;
            r_in_ckp_q  <= w_in_ckp;
            r_lap_pulse <= w_lap_done;
            if (w_rearm || w_arm) begin
                r_lap      <= 3'd0;
                r_lap_time <= 16'd0;
                r_presc    <= '0;
            end else if (w_lap_done) begin
                r_lap      <= r_lap + 3'd1;
                r_last_lap <= r_lap_time;
                r_lap_time <= 16'd0;
                r_presc    <= '0;
            end else if (w_count_en) begin
                if (w_wrap) begin
                    r_presc    <= '0;
                    r_lap_time <= sat_inc16(r_lap_time);
                end else begin
                    r_presc <= r_presc + PS_W'(1);
                end
            end
        end
    end

`ifdef BEST_LAP_EN
    logic [15:0] r_best_lap;

    // Best lap survives re-arming between races; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_lap <= 16'hFFFF;
        end else if (w_lap_done) begin
            r_best_lap <= min16(r_best_lap, r_lap_time);
        end
    end

    assign best_lap_cs = r_best_lap;
`else
    assign best_lap_cs = min16(16'hFFFF, 16'hFFFF);
`endif

    assign lap         = r_lap;
    assign lap_time_cs = r_lap_time;
    assign last_lap_cs = r_last_lap;
    assign lap_pulse   = r_lap_pulse;
    assign race_done   = w_race_done;

endmodule
